mul_hilo_wb: RTL and testbench

- Issue/writeback stage wrapped around the 32-bit pipelined Dadda multiplier (mul32p).
- Upstream: accepts multiply requests with a valid/ready handshake and drives the operands and mode to the multiplier.
- Tracks each operation's valid bit and tag through the multiplier's fixed latency.
- Downstream: captures each {hi, lo} product into a result FIFO, drained by a valid/ready consumer.
- The multiplier pipeline cannot stall, so the block uses credit-based issue to guarantee the FIFO never overflows.

---
 rtl/mul_hilo_wb.sv | 173 +++++++++++++++++
 tb/tb_mul_hilo_wb.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_hilo_wb.sv
// mul_hilo_wb: issue/writeback stage around the 32-bit pipelined multiplier.
//
// Requests are accepted with a valid/ready handshake and their operands go
// straight to the multiplier. A LAT-deep {valid, tag} shift register follows
// each operation through the multiplier's fixed latency. When an operation
// reaches the last stage, its {tag, hi, lo} is written into a DEPTH-entry
// result FIFO that a valid/ready consumer drains. The multiplier cannot stall,
// so issue is credit based: one credit per FIFO entry, taken on issue and
// returned on pop. This keeps the FIFO from overflowing.
//
// Parameters:
//   LAT   multiplier latency in rising edges (1..8)
//   DEPTH result FIFO entries / credit pool size (2..16)
//   TAGW  request tag width
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_a, req_b, req_mode, req_tag   operands, 1 = signed, request tag
//   mul_a, mul_b, mul_mode            operands to multiplier (pass-through)
//   mul_lo, mul_hi                    product from multiplier
//   rsp_valid/rsp_ready               result handshake
//   rsp_lo, rsp_hi, rsp_tag           head-of-FIFO product and tag
//
// Optional feature (macro MUL_HILO_REG_EN):
//   hilo_hi, hilo_lo                  architectural HI/LO registers, loaded
//                                     on every result pop, reset to 0.

module mul_hilo_wb #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic            req_mode,
  input  logic [TAGW-1:0] req_tag,
  output logic [31:0]     mul_a,
  output logic [31:0]     mul_b,
  output logic            mul_mode,
  input  logic [31:0]     mul_lo,
  input  logic [31:0]     mul_hi,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_lo,
  output logic [31:0]     rsp_hi,
  output logic [TAGW-1:0] rsp_tag
`ifdef MUL_HILO_REG_EN
  ,
  output logic [31:0]     hilo_hi,
  output logic [31:0]     hilo_lo
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            v_sr   [LAT];
  logic [TAGW-1:0] tag_sr [LAT];

  logic [31:0]     lo_mem  [DEPTH];
  logic [31:0]     hi_mem  [DEPTH];
  logic [TAGW-1:0] tag_mem [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] credits;

  logic issue;
  logic push;
  logic pop;

  assign mul_a    = req_a;
  assign mul_b    = req_b;
  assign mul_mode = req_mode;

  // req_ready depends only on the credit register, so a credit freed by a
  // pop becomes usable one cycle later and rsp_ready never reaches req_ready.
  assign req_ready = (credits != '0);
  assign rsp_valid = (count != '0);

  assign issue = req_valid && req_ready;
  assign push  = v_sr[LAT-1];
  assign pop   = rsp_valid && rsp_ready;

  assign rsp_lo  = lo_mem[rptr];
  assign rsp_hi  = hi_mem[rptr];
  assign rsp_tag = tag_mem[rptr];

  // Latency tracker: bubbles travel with the data, nothing is collapsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        v_sr[i]   <= 1'b0;
        tag_sr[i] <= '0;
      end
    end else begin
      v_sr[0]   <= issue;
      tag_sr[0] <= req_tag;
      for (int unsigned i = 1; i < LAT; i++) begin
        v_sr[i]   <= v_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  // Result FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        lo_mem[i]  <= '0;
        hi_mem[i]  <= '0;
        tag_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        lo_mem[wptr]  <= mul_lo;
        hi_mem[wptr]  <= mul_hi;
        tag_mem[wptr] <= tag_sr[LAT-1];
        wptr          <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      end
    end
  end

  // Occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Credit pool: inflight + count + credits == DEPTH at every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CW'(DEPTH);
    end else begin
      case ({issue, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

`ifdef MUL_HILO_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hilo_hi <= '0;
      hilo_lo <= '0;
    end else if (pop) begin
      hilo_hi <= rsp_hi;
      hilo_lo <= rsp_lo;
    end
  end
`endif

endmodule

// File: tb/tb_mul_hilo_wb.sv
// Self-checking bench for mul_hilo_wb. A behavioural multiplier with LAT
// pipeline stages stands in for mul32p; expected results come from a queue
// of products computed with plain 64-bit arithmetic at issue time.

module tb_mul_hilo_wb;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAGW  = 4;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic            req_mode;
  logic [TAGW-1:0] req_tag;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic            mul_mode;
  logic [31:0]     mul_lo;
  logic [31:0]     mul_hi;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_lo;
  logic [31:0]     rsp_hi;
  logic [TAGW-1:0] rsp_tag;
`ifdef MUL_HILO_REG_EN
  logic [31:0]     hilo_hi;
  logic [31:0]     hilo_lo;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [63:0]     p;
  } exp_t;

  exp_t q[$];

  mul_hilo_wb #(
    .LAT   (LAT),
    .DEPTH (DEPTH),
    .TAGW  (TAGW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_mode  (req_mode),
    .req_tag   (req_tag),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_mode  (mul_mode),
    .mul_lo    (mul_lo),
    .mul_hi    (mul_hi),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_lo    (rsp_lo),
    .rsp_hi    (rsp_hi),
    .rsp_tag   (rsp_tag)
`ifdef MUL_HILO_REG_EN
    ,
    .hilo_hi   (hilo_hi),
    .hilo_lo   (hilo_lo)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in multiplier: unsigned product with two's-complement correction
  // terms for signed mode, delayed by LAT edges. Runs regardless of reset.
  function automatic logic [63:0] env_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic m);
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, b};
    if (m && a[31]) p = p - {b, 32'h0};
    if (m && b[31]) p = p - {a, 32'h0};
    return p;
  endfunction

  logic [63:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= env_mul(mul_a, mul_b, mul_mode);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_lo = mpipe[LAT-1][31:0];
  assign mul_hi = mpipe[LAT-1][63:32];

  // Reference product from the arithmetic definition.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic m);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (m) begin
      sa = 64'($signed(a));
      sb = 64'($signed(b));
      return sa * sb;
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (rsp_lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h expected 0", rsp_lo); end
    n_cmp++; if (rsp_hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h expected 0", rsp_hi); end
    n_cmp++; if (rsp_tag !== '0) begin n_bad++; $display("FAIL reset_tag: got %h expected 0", rsp_tag); end
`ifdef MUL_HILO_REG_EN
    n_cmp++; if ({hilo_hi, hilo_lo} !== 64'h0) begin n_bad++; $display("FAIL reset_hilo: got %h expected 0", {hilo_hi, hilo_lo}); end
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_unsigned_basic();
    int lat;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a = 32'd292;
    req_b = 32'd6785;
    req_mode = 1'b0;
    req_tag = TAGW'(3);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %b expected 1", req_ready); end
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 4 * LAT + 8) begin
      tick();
      lat++;
    end
    n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
    n_cmp++; if (rsp_lo !== 32'd1981220) begin n_bad++; $display("FAIL basic_lo: got %0d expected 1981220", rsp_lo); end
    n_cmp++; if (rsp_hi !== 32'd0) begin n_bad++; $display("FAIL basic_hi: got %0d expected 0", rsp_hi); end
    n_cmp++; if (rsp_tag !== TAGW'(3)) begin n_bad++; $display("FAIL basic_tag: got %0d expected 3", rsp_tag); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL basic_empty: got %b expected 0", rsp_valid); end
`ifdef MUL_HILO_REG_EN
    n_cmp++; if (hilo_lo !== 32'd1981220) begin n_bad++; $display("FAIL hilo_lo: got %0d expected 1981220", hilo_lo); end
    n_cmp++; if (hilo_hi !== 32'd0) begin n_bad++; $display("FAIL hilo_hi: got %0d expected 0", hilo_hi); end
    repeat (3) tick();
    n_cmp++; if ({hilo_hi, hilo_lo} !== {32'd0, 32'd1981220}) begin n_bad++; $display("FAIL hilo_hold: got %h expected %h", {hilo_hi, hilo_lo}, {32'd0, 32'd1981220}); end
`endif
  endtask

  task automatic test_signed();
    logic [31:0]     exp_hi  [2];
    logic [31:0]     exp_lo  [2];
    logic [TAGW-1:0] exp_tag [2];
    int got;
    int cyc;
    exp_hi[0] = 32'hFFFFFFFF; exp_lo[0] = 32'hFFFFFFFE; exp_tag[0] = TAGW'(5);
    exp_hi[1] = 32'h00000001; exp_lo[1] = 32'hFFFFFFFE; exp_tag[1] = TAGW'(6);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a = 32'hFFFFFFFF;
    req_b = 32'd2;
    req_mode = 1'b1;
    req_tag = TAGW'(5);
    tick();
    req_mode = 1'b0;
    req_tag = TAGW'(6);
    tick();
    req_valid = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 2 && cyc < 20) begin
      if (rsp_valid === 1'b1) begin
        n_cmp++;
        if ({rsp_tag, rsp_hi, rsp_lo} !== {exp_tag[got], exp_hi[got], exp_lo[got]}) begin
          n_bad++;
          $display("FAIL signed_result%0d: got tag %h hi %h lo %h expected tag %h hi %h lo %h",
                   got, rsp_tag, rsp_hi, rsp_lo, exp_tag[got], exp_hi[got], exp_lo[got]);
        end
        got++;
      end
      tick();
      cyc++;
    end
    n_cmp++; if (got != 2) begin n_bad++; $display("FAIL signed_count: got %0d expected 2", got); end
  endtask

  task automatic test_backpressure();
    int acc;
    int cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic m;
    exp_t e;
    rsp_ready = 1'b0;
    acc = 0;
    a = $urandom; b = $urandom; m = 1'($urandom_range(0, 1));
    for (int c = 0; c < int'(DEPTH + LAT + 4); c++) begin
      req_valid = 1'b1;
      req_a = a; req_b = b; req_mode = m; req_tag = TAGW'(acc);
      n_cmp++;
      if (req_ready !== 1'(acc < int'(DEPTH))) begin
        n_bad++;
        $display("FAIL bp_ready_c%0d: got %b expected %b", c, req_ready, 1'(acc < int'(DEPTH)));
      end
      if (req_ready === 1'b1) begin
        q.push_back('{tag: TAGW'(acc), p: ref_prod(a, b, m)});
        acc++;
        a = $urandom; b = $urandom; m = 1'($urandom_range(0, 1));
      end
      tick();
      req_a = a; req_b = b; req_mode = m;
    end
    n_cmp++; if (acc != int'(DEPTH)) begin n_bad++; $display("FAIL bp_accepted: got %0d expected %0d", acc, DEPTH); end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_tag !== '0) begin n_bad++; $display("FAIL bp_head: got valid %b tag %h expected valid 1 tag 0", rsp_valid, rsp_tag); end
    rsp_ready = 1'b1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_during_pop: got %b expected 0", req_ready); end
    e = q.pop_front();
    n_cmp++; if ({rsp_tag, rsp_hi, rsp_lo} !== {e.tag, e.p}) begin n_bad++; $display("FAIL bp_pop: got %h expected %h", {rsp_tag, rsp_hi, rsp_lo}, {e.tag, e.p}); end
    tick();
    rsp_ready = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_pop: got %b expected 1", req_ready); end
    if (req_ready === 1'b1) q.push_back('{tag: TAGW'(acc), p: ref_prod(req_a, req_b, req_mode)});
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 40) begin
      if (rsp_valid === 1'b1) begin
        e = q.pop_front();
        n_cmp++;
        if ({rsp_tag, rsp_hi, rsp_lo} !== {e.tag, e.p}) begin
          n_bad++;
          $display("FAIL bp_drain: got %h expected %h", {rsp_tag, rsp_hi, rsp_lo}, {e.tag, e.p});
        end
      end
      tick();
      cyc++;
    end
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL bp_drain_done: got %0d left expected 0", q.size()); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] aa [8];
    logic [31:0] bb [8];
    logic        mm [8];
    int sent;
    int got;
    int first_cyc;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      aa[i] = $urandom; bb[i] = $urandom; mm[i] = 1'($urandom_range(0, 1));
    end
    aa[0] = 32'h80000000; bb[0] = 32'h80000000; mm[0] = 1'b1;
    aa[1] = 32'hFFFFFFFF; bb[1] = 32'hFFFFFFFF; mm[1] = 1'b0;
    rsp_ready = 1'b1;
    sent = 0;
    got = 0;
    first_cyc = -1;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (rsp_valid === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_extra: got unexpected tag %h expected none", rsp_tag);
        end else begin
          e = q.pop_front();
          if ({rsp_tag, rsp_hi, rsp_lo} !== {e.tag, e.p}) begin
            n_bad++;
            $display("FAIL b2b_result%0d: got %h expected %h", got, {rsp_tag, rsp_hi, rsp_lo}, {e.tag, e.p});
          end
        end
        if (got == 0) first_cyc = c;
        got++;
      end else if (got > 0 && got < 8) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b2b_gap_c%0d: got rsp_valid 0 expected 1", c);
      end
      if (sent < 8) begin
        req_valid = 1'b1;
        req_a = aa[sent]; req_b = bb[sent]; req_mode = mm[sent]; req_tag = TAGW'(sent);
        if (req_ready === 1'b1) begin
          q.push_back('{tag: TAGW'(sent), p: ref_prod(aa[sent], bb[sent], mm[sent])});
          sent++;
        end
      end else begin
        req_valid = 1'b0;
      end
      tick();
    end
    req_valid = 1'b0;
    n_cmp++; if (got != 8) begin n_bad++; $display("FAIL b2b_count: got %0d expected 8", got); end
    n_cmp++; if (first_cyc != int'(LAT + 1)) begin n_bad++; $display("FAIL b2b_first: got %0d expected %0d", first_cyc, LAT + 1); end
  endtask

  task automatic test_reset_midflight();
    int acc;
    int cyc;
    exp_t e;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_a = $urandom; req_b = $urandom; req_mode = 1'($urandom_range(0, 1));
      req_tag = TAGW'(8 + i);
      tick();
    end
    req_valid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL mf_setup: got %b expected 1", rsp_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mf_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mf_ready: got %b expected 1", req_ready); end
`ifdef MUL_HILO_REG_EN
    n_cmp++; if ({hilo_hi, hilo_lo} !== 64'h0) begin n_bad++; $display("FAIL mf_hilo: got %h expected 0", {hilo_hi, hilo_lo}); end
`endif
    q.delete();
    tick();
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      n_cmp++;
      if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mf_stale_c%0d: got %b expected 0", c, rsp_valid); end
      tick();
    end
    // Credits must be back to the full pool after reset.
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < int'(DEPTH + LAT + 2); c++) begin
      req_valid = 1'b1;
      req_a = $urandom; req_b = $urandom; req_mode = 1'($urandom_range(0, 1));
      req_tag = TAGW'(acc);
      if (req_ready === 1'b1) begin
        q.push_back('{tag: TAGW'(acc), p: ref_prod(req_a, req_b, req_mode)});
        acc++;
      end
      tick();
    end
    req_valid = 1'b0;
    n_cmp++; if (acc != int'(DEPTH)) begin n_bad++; $display("FAIL mf_credits: got %0d expected %0d", acc, DEPTH); end
    rsp_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 40) begin
      if (rsp_valid === 1'b1) begin
        e = q.pop_front();
        n_cmp++;
        if ({rsp_tag, rsp_hi, rsp_lo} !== {e.tag, e.p}) begin
          n_bad++;
          $display("FAIL mf_drain: got %h expected %h", {rsp_tag, rsp_hi, rsp_lo}, {e.tag, e.p});
        end
      end
      tick();
      cyc++;
    end
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL mf_drain_done: got %0d left expected 0", q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_mode = 1'b0;
    req_tag = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
